// File: rtl/stv_stream_arbiter_if.sv
// Handshake bundle for stv_stream_arbiter: N upstream requesters, one downstream sink.
// master = the side driving requests and downstream ready; slave = the arbiter.
interface stv_stream_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int GW = $clog2(N);

  logic [N-1:0]       valid_in;
  logic [N*WIDTH-1:0] data_in;
  logic [N-1:0]       last_in;
  logic [N-1:0]       ready_out;
  logic               ready_in;
  logic               valid_out;
  logic [WIDTH-1:0]   data_out;
  logic               last_out;
  logic [GW-1:0]      grant_out;

  modport master (
    output valid_in, data_in, last_in, ready_in,
    input  ready_out, valid_out, data_out, last_out, grant_out
  );

  modport slave (
    input  valid_in, data_in, last_in, ready_in,
    output ready_out, valid_out, data_out, last_out, grant_out
  );
endinterface

// File: rtl/stv_stream_arbiter.sv
// Round-robin N:1 stream arbiter feeding a 2-entry skid output stage.
// Define STV_STREAM_ARB_LOCK_EN to hold the grant on a requester until its last beat.
//
// state      | meaning
// ST_IDLE    | output stage empty, valid_out low
// ST_STREAM  | one beat held in the output register
// ST_SKID    | output register plus skid entry full, upstream stalled
module stv_stream_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               arst_n,
  stv_stream_arbiter_if.slave bus
);
  localparam int GW = $clog2(N);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_STREAM = 2'd1;
  localparam logic [1:0] ST_SKID   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] head_data_q, head_data_d, skid_data_q, skid_data_d;
  logic             head_last_q, head_last_d, skid_last_q, skid_last_d;
  logic [GW-1:0]    head_grant_q, head_grant_d, skid_grant_q, skid_grant_d;
`ifdef STV_STREAM_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [GW-1:0]    lock_idx_q, lock_idx_d;
`endif

  logic             stage_ready;
  logic             accept;
  logic             drain;
  logic             found;
  logic [N-1:0]     sel;
  logic [N-1:0]     ready_vec;
  logic [GW-1:0]    sel_idx;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N) s = s - N;
    return GW'(s);
  endfunction

  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && bus.valid_in[rr_idx(ptr_q, k)]) begin
        found   = 1'b1;
        sel_idx = rr_idx(ptr_q, k);
      end
    end
    sel = found ? (N'(1) << sel_idx) : '0;
`ifdef STV_STREAM_ARB_LOCK_EN
    // a locked requester that pauses stalls everyone rather than yielding
    if (lock_q) begin
      sel_idx = lock_idx_q;
      sel     = bus.valid_in[lock_idx_q] ? (N'(1) << lock_idx_q) : '0;
    end
`endif
  end

  assign stage_ready   = (state_q != ST_SKID);
  assign ready_vec     = (stage_ready && arst_n) ? sel : '0;
  assign bus.ready_out = ready_vec;
  assign accept        = |(bus.valid_in & ready_vec);
  assign drain         = (state_q != ST_IDLE) && bus.ready_in;
  assign in_data       = bus.data_in[sel_idx*WIDTH +: WIDTH];
  assign in_last       = bus.last_in[sel_idx];

  always_comb begin
    state_d      = state_q;
    head_data_d  = head_data_q;
    head_last_d  = head_last_q;
    head_grant_d = head_grant_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    skid_grant_d = skid_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          head_data_d  = in_data;
          head_last_d  = in_last;
          head_grant_d = sel_idx;
          state_d      = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (accept && drain) begin
          head_data_d  = in_data;
          head_last_d  = in_last;
          head_grant_d = sel_idx;
        end else if (accept) begin
          skid_data_d  = in_data;
          skid_last_d  = in_last;
          skid_grant_d = sel_idx;
          state_d      = ST_SKID;
        end else if (drain) begin
          state_d      = ST_IDLE;
        end
      end
      ST_SKID: begin
        if (drain) begin
          head_data_d  = skid_data_q;
          head_last_d  = skid_last_q;
          head_grant_d = skid_grant_q;
          state_d      = ST_STREAM;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef STV_STREAM_ARB_LOCK_EN
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (accept) begin
      lock_d     = !in_last;
      lock_idx_d = sel_idx;
      if (in_last) ptr_d = rr_idx(sel_idx, 1);
    end
`else
    if (accept) ptr_d = rr_idx(sel_idx, 1);
`endif
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
`ifdef STV_STREAM_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
`ifdef STV_STREAM_ARB_LOCK_EN
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
`endif
    end
  end

  // payload registers are qualified by state, so they carry no reset
  always_ff @(posedge clk) begin
    head_data_q  <= head_data_d;
    head_last_q  <= head_last_d;
    head_grant_q <= head_grant_d;
    skid_data_q  <= skid_data_d;
    skid_last_q  <= skid_last_d;
    skid_grant_q <= skid_grant_d;
  end

  assign bus.valid_out = (state_q != ST_IDLE);
  assign bus.data_out  = head_data_q;
  assign bus.last_out  = head_last_q;
  assign bus.grant_out = head_grant_q;
endmodule

// File: tb/tb_stv_stream_arbiter.sv
// Directed bench for stv_stream_arbiter: round-robin order, skid stall, packet lock
// (when STV_STREAM_ARB_LOCK_EN is defined) and asynchronous reset recovery.
module tb_stv_stream_arbiter;
  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic arst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  int exp_g1[4] = '{1, 3, 1, 3};
  int exp_g5[5] = '{2, 3, 2, 3, 2};

  always #5 clk = ~clk;

  stv_stream_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

  stv_stream_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [WIDTH-1:0] d);
    bus.data_in[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic do_reset();
    arst_n       = 1'b0;
    bus.valid_in = '0;
    bus.last_in  = '0;
    bus.ready_in = 1'b0;
    repeat (2) tick();
    check("rst_valid_out", bus.valid_out, 1'b0);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n       = 1'b0;
    bus.valid_in = 4'b1111;
    bus.last_in  = 4'b1111;
    bus.data_in  = '0;
    bus.ready_in = 1'b1;
    repeat (2) tick();
    check("rst_hold_valid_out", bus.valid_out, 1'b0);
    check("rst_hold_ready_out", bus.ready_out, 4'b0000);

    // alternating pair 1/3
    do_reset();
    bus.valid_in = 4'b1010;
    bus.last_in  = 4'b1111;
    bus.ready_in = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, 8'hA0 + 8'(i));
    #1;
    check("alt_ready_pre", bus.ready_out, 4'b0010);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("alt_grant", bus.grant_out, exp_g1[k]);
      check("alt_valid", bus.valid_out, 1'b1);
      check("alt_data",  bus.data_out, 8'hA0 + 8'(exp_g1[k]));
    end

    // all requesters, full throughput
    do_reset();
    bus.valid_in = 4'b1111;
    bus.last_in  = 4'b1111;
    bus.ready_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rr_grant", bus.grant_out, k % 4);
      check("rr_valid", bus.valid_out, 1'b1);
      check("rr_data",  bus.data_out, 8'hA0 + 8'(k % 4));
    end

    // skid: downstream stalls for three cycles
    do_reset();
    bus.valid_in = 4'b0001;
    bus.last_in  = 4'b1111;
    bus.ready_in = 1'b0;
    set_data(0, 8'h11);
    tick();
    check("skid_b1_valid", bus.valid_out, 1'b1);
    check("skid_b1_data",  bus.data_out, 8'h11);
    set_data(0, 8'h22);
    #1;
    check("skid_stream_ready", bus.ready_out, 4'b0001);
    tick();
    check("skid_full_ready", bus.ready_out, 4'b0000);
    check("skid_full_data",  bus.data_out, 8'h11);
    set_data(0, 8'h33);
    tick();
    check("skid_hold_ready", bus.ready_out, 4'b0000);
    check("skid_hold_data",  bus.data_out, 8'h11);
    bus.ready_in = 1'b1;
    #1;
    check("skid_ready_indep", bus.ready_out, 4'b0000);
    bus.valid_in = 4'b0000;
    tick();
    check("skid_b2_valid", bus.valid_out, 1'b1);
    check("skid_b2_data",  bus.data_out, 8'h22);
    tick();
    check("skid_empty_valid", bus.valid_out, 1'b0);

    // requester 2 three-beat packet against requester 3
    do_reset();
    bus.ready_in = 1'b1;
    bus.valid_in = 4'b1100;
    bus.last_in  = 4'b1000;
    set_data(3, 8'h30);
    set_data(2, 8'h21);
    #1;
    check("pkt_ready_pre", bus.ready_out, 4'b0100);
`ifdef STV_STREAM_ARB_LOCK_EN
    tick();
    check("lock_b1_grant", bus.grant_out, 2);
    check("lock_b1_data",  bus.data_out, 8'h21);
    check("lock_b1_last",  bus.last_out, 1'b0);
    bus.valid_in = 4'b1000;
    #1;
    check("lock_pause_ready", bus.ready_out, 4'b0000);
    tick();
    check("lock_pause_valid", bus.valid_out, 1'b0);
    bus.valid_in = 4'b1100;
    set_data(2, 8'h22);
    tick();
    check("lock_b2_grant", bus.grant_out, 2);
    check("lock_b2_data",  bus.data_out, 8'h22);
    set_data(2, 8'h23);
    bus.last_in = 4'b1100;
    tick();
    check("lock_b3_grant", bus.grant_out, 2);
    check("lock_b3_data",  bus.data_out, 8'h23);
    check("lock_b3_last",  bus.last_out, 1'b1);
    bus.last_in = 4'b1000;
    tick();
    check("lock_next_grant", bus.grant_out, 3);
    check("lock_next_data",  bus.data_out, 8'h30);
`else
    for (int k = 0; k < 5; k++) begin
      tick();
      check("nolock_grant", bus.grant_out, exp_g5[k]);
      check("nolock_data",  bus.data_out, (exp_g5[k] == 2) ? 8'h21 : 8'h30);
      check("nolock_last",  bus.last_out, (exp_g5[k] == 3) ? 1'b1 : 1'b0);
    end
`endif

    // reset with two beats held mid-packet
    do_reset();
    bus.valid_in = 4'b0001;
    bus.last_in  = 4'b0000;
    bus.ready_in = 1'b0;
    set_data(0, 8'h40);
    tick();
    check("mid_b1_valid", bus.valid_out, 1'b1);
    tick();
    check("mid_skid_ready", bus.ready_out, 4'b0000);
    #2;
    arst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.valid_out, 1'b0);
    check("mid_rst_ready", bus.ready_out, 4'b0000);
    @(negedge clk);
    arst_n       = 1'b1;
    bus.valid_in = 4'b1010;
    bus.last_in  = 4'b1111;
    bus.ready_in = 1'b1;
    #1;
    check("post_rst_valid", bus.valid_out, 1'b0);
    check("post_rst_unlocked", bus.ready_out, 4'b0010);
    bus.valid_in = 4'b1001;
    set_data(0, 8'h41);
    set_data(3, 8'h43);
    #1;
    check("post_rst_ptr", bus.ready_out, 4'b0001);
    tick();
    check("post_rst_grant", bus.grant_out, 0);
    check("post_rst_data",  bus.data_out, 8'h41);
    check("post_rst_valid2", bus.valid_out, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
